// File: rtl/mem_stage_lsu_if.sv
// Data-memory bus between the LSU (master) and the data memory (slave).
// req/we/addr/wdata flow to memory; gnt/rvalid/rdata flow back.
interface mem_stage_lsu_if;
    logic        req;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: ALU pass-through, lane-aligned store/load
// over the dmem bus, registered writeback pulse, stall while busy.
// Ports: clk, reset (async, active-high), in_* from the EX/MEM register,
// stall, dmem (master bus), wb_* writeback, misalign (only with
// LSU_MISALIGN_CHECK_EN defined).
module mem_stage_lsu (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_rv2,
    input  logic [4:0]  in_rd,
    input  logic [2:0]  in_func3,
    input  logic [3:0]  in_dwe,
    input  logic        in_mem_reg,
    input  logic        in_reg_wr,
    output logic        stall,
    mem_stage_lsu_if.master dmem,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_wr,
    output logic [31:0] wb_data
`ifdef LSU_MISALIGN_CHECK_EN
    ,
    output logic        misalign
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    state_t state, state_n;

    logic [31:0] a_addr;
    logic [31:0] a_rv2;
    logic [4:0]  a_rd;
    logic [2:0]  a_func3;
    logic [3:0]  a_dwe;
    logic        a_reg_wr;

    logic        mem_op;
    logic        a_store;
    logic        launch;
    logic        wb_set;
    logic [4:0]  wb_set_rd;
    logic        wb_set_wr;
    logic [31:0] wb_set_data;
    logic        mis_set;
    logic [31:0] ld_shift;
    logic [31:0] ld_data;

    assign mem_op  = (|in_dwe) | in_mem_reg;
    assign a_store = |a_dwe;
    assign stall   = (state != IDLE);

    // Bus outputs are gated by state so they are zero outside REQ,
    // which also makes reset drop the request immediately.
    always_comb begin
        dmem.req   = 1'b0;
        dmem.we    = 4'b0000;
        dmem.addr  = 32'h0;
        dmem.wdata = 32'h0;
        if (state == REQ) begin
            dmem.req   = 1'b1;
            dmem.addr  = {a_addr[31:2], 2'b00};
            dmem.we    = a_store ? (a_dwe << a_addr[1:0]) : 4'b0000;
            dmem.wdata = a_rv2 << {a_addr[1:0], 3'b000};
        end
    end

    assign ld_shift = dmem.rdata >> {a_addr[1:0], 3'b000};

    always_comb begin
        ld_data = ld_shift;
        unique case (1'b1)
            (a_func3 == 3'b000): ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
            (a_func3 == 3'b001): ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
            (a_func3 == 3'b100): ld_data = {24'h0, ld_shift[7:0]};
            (a_func3 == 3'b101): ld_data = {16'h0, ld_shift[15:0]};
            default:             ld_data = ld_shift;
        endcase
    end

    always_comb begin
        state_n     = state;
        launch      = 1'b0;
        wb_set      = 1'b0;
        wb_set_rd   = a_rd;
        wb_set_wr   = 1'b0;
        wb_set_data = a_addr;
        mis_set     = 1'b0;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    if (!mem_op) begin
                        wb_set      = 1'b1;
                        wb_set_rd   = in_rd;
                        wb_set_wr   = in_reg_wr;
                        wb_set_data = in_addr;
`ifdef LSU_MISALIGN_CHECK_EN
                    end else if (((in_func3[1:0] == 2'b01) && in_addr[0]) ||
                                 ((in_func3[1:0] == 2'b10) && (|in_addr[1:0]))) begin
                        wb_set      = 1'b1;
                        wb_set_rd   = in_rd;
                        wb_set_data = in_addr;
                        mis_set     = 1'b1;
`endif
                    end else begin
                        launch  = 1'b1;
                        state_n = REQ;
                    end
                end
            end
            REQ: begin
                if (dmem.gnt) begin
                    if (a_store) begin
                        wb_set  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        state_n = WAIT;
                    end
                end
            end
            WAIT: begin
                if (dmem.rvalid) begin
                    wb_set      = 1'b1;
                    wb_set_wr   = a_reg_wr;
                    wb_set_data = ld_data;
                    state_n     = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_addr   <= 32'h0;
            a_rv2    <= 32'h0;
            a_rd     <= 5'd0;
            a_func3  <= 3'd0;
            a_dwe    <= 4'd0;
            a_reg_wr <= 1'b0;
        end else if (launch) begin
            a_addr   <= in_addr;
            a_rv2    <= in_rv2;
            a_rd     <= in_rd;
            a_func3  <= in_func3;
            a_dwe    <= in_dwe;
            a_reg_wr <= in_reg_wr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid  <= 1'b0;
            wb_reg_wr <= 1'b0;
            wb_rd     <= 5'd0;
            wb_data   <= 32'h0;
        end else begin
            wb_valid  <= wb_set;
            wb_reg_wr <= wb_set & wb_set_wr;
            if (wb_set) begin
                wb_rd   <= wb_set_rd;
                wb_data <= wb_set_data;
            end
        end
    end

`ifdef LSU_MISALIGN_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misalign <= 1'b0;
        end else begin
            misalign <= mis_set;
        end
    end
`else
    logic unused_mis;
    assign unused_mis = mis_set;
`endif

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: directed ALU/load/store/reset
// vectors; a negedge monitor checks every writeback pulse.
module tb_mem_stage_lsu;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_addr;
    logic [31:0] in_rv2;
    logic [4:0]  in_rd;
    logic [2:0]  in_func3;
    logic [3:0]  in_dwe;
    logic        in_mem_reg;
    logic        in_reg_wr;
    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_reg_wr;
    logic [31:0] wb_data;
    logic        mis_obs;

    mem_stage_lsu_if dmem ();

    mem_stage_lsu dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_addr    (in_addr),
        .in_rv2     (in_rv2),
        .in_rd      (in_rd),
        .in_func3   (in_func3),
        .in_dwe     (in_dwe),
        .in_mem_reg (in_mem_reg),
        .in_reg_wr  (in_reg_wr),
        .stall      (stall),
        .dmem       (dmem.master),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_reg_wr  (wb_reg_wr),
        .wb_data    (wb_data)
`ifdef LSU_MISALIGN_CHECK_EN
        ,
        .misalign   (mis_obs)
`endif
    );

`ifndef LSU_MISALIGN_CHECK_EN
    assign mis_obs = 1'b0;
`endif

    typedef struct packed {
        logic [4:0]  rd;
        logic        reg_wr;
        logic [31:0] data;
        logic        chk_data;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (wb_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL wb_unexpected: rd=%0d data=%h", wb_rd, wb_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (wb_rd !== e.rd || wb_reg_wr !== e.reg_wr ||
                        mis_obs !== e.mis ||
                        (e.chk_data && wb_data !== e.data)) begin
                        errors++;
                        $display("FAIL wb_pulse: got rd=%0d wr=%b mis=%b data=%h expected rd=%0d wr=%b mis=%b data=%h",
                                 wb_rd, wb_reg_wr, mis_obs, wb_data,
                                 e.rd, e.reg_wr, e.mis, e.data);
                    end
                end
            end else begin
                checks++;
                if (wb_reg_wr !== 1'b0 || mis_obs !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_wb: got wr=%b mis=%b expected 0 0",
                             wb_reg_wr, mis_obs);
                end
            end
        end
    end

    task automatic drive(input logic [31:0] a, input logic [31:0] d,
                         input logic [4:0] rd, input logic [2:0] f3,
                         input logic [3:0] dwe, input logic mreg,
                         input logic rwr);
        in_valid   = 1'b1;
        in_addr    = a;
        in_rv2     = d;
        in_rd      = rd;
        in_func3   = f3;
        in_dwe     = dwe;
        in_mem_reg = mreg;
        in_reg_wr  = rwr;
    endtask

    task automatic do_load(input logic [31:0] a, input logic [2:0] f3,
                           input logic [31:0] rdat, input logic [31:0] exp);
        @(posedge clk); #1;
        drive(a, 32'h0, 5'd7, f3, 4'b0000, 1'b1, 1'b1);
        exp_q.push_back('{rd: 5'd7, reg_wr: 1'b1, data: exp, chk_data: 1'b1, mis: 1'b0});
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("ld_req", 32'(dmem.req), 32'd1);
        chk("ld_we", 32'(dmem.we), 32'd0);
        chk("ld_addr", dmem.addr, {a[31:2], 2'b00});
        @(posedge clk); #1;
        dmem.gnt    = 1'b1;
        dmem.rvalid = 1'b1;
        dmem.rdata  = 32'hDEADBEEF;
        @(posedge clk); #1;
        dmem.gnt    = 1'b0;
        dmem.rvalid = 1'b0;
        @(negedge clk);
        chk("ld_wait_stall", 32'(stall), 32'd1);
        chk("ld_wait_req", 32'(dmem.req), 32'd0);
        @(posedge clk); #1;
        dmem.rvalid = 1'b1;
        dmem.rdata  = rdat;
        @(posedge clk); #1;
        dmem.rvalid = 1'b0;
        @(negedge clk);
        chk("ld_done_stall", 32'(stall), 32'd0);
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] dwe, input logic [3:0] ewe,
                            input logic [31:0] ewd);
        @(posedge clk); #1;
        drive(a, d, 5'd3, 3'b010, dwe, 1'b0, 1'b0);
        exp_q.push_back('{rd: 5'd3, reg_wr: 1'b0, data: 32'h0, chk_data: 1'b0, mis: 1'b0});
        @(posedge clk); #1;
        in_valid = 1'b0;
        dmem.gnt = 1'b1;
        @(negedge clk);
        chk("st_req", 32'(dmem.req), 32'd1);
        chk("st_we", 32'(dmem.we), 32'(ewe));
        chk("st_addr", dmem.addr, {a[31:2], 2'b00});
        chk("st_wdata", dmem.wdata, ewd);
        @(posedge clk); #1;
        dmem.gnt = 1'b0;
        @(negedge clk);
        chk("st_done_stall", 32'(stall), 32'd0);
    endtask

    task automatic do_misalign(input logic [31:0] a, input logic [2:0] f3,
                               input logic [3:0] dwe, input logic mreg);
        @(posedge clk); #1;
        drive(a, 32'h0, 5'd11, f3, dwe, mreg, 1'b1);
        exp_q.push_back('{rd: 5'd11, reg_wr: 1'b0, data: 32'h0, chk_data: 1'b0, mis: 1'b1});
        @(negedge clk);
        chk("mis_req_pre", 32'(dmem.req), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("mis_req", 32'(dmem.req), 32'd0);
        chk("mis_stall", 32'(stall), 32'd0);
    endtask

    initial begin
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_addr     = 32'h0;
        in_rv2      = 32'h0;
        in_rd       = 5'd0;
        in_func3    = 3'd0;
        in_dwe      = 4'd0;
        in_mem_reg  = 1'b0;
        in_reg_wr   = 1'b0;
        dmem.gnt    = 1'b0;
        dmem.rvalid = 1'b0;
        dmem.rdata  = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_req", 32'(dmem.req), 32'd0);
        chk("rst_we", 32'(dmem.we), 32'd0);
        chk("rst_addr", dmem.addr, 32'h0);
        chk("rst_wdata", dmem.wdata, 32'h0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_reg_wr", 32'(wb_reg_wr), 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_wb_data", wb_data, 32'h0);
        chk("rst_misalign", 32'(mis_obs), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // idle with no valid: nothing happens
        repeat (3) begin
            @(negedge clk);
            chk("idle_req", 32'(dmem.req), 32'd0);
        end

        // ALU pass-through
        @(posedge clk); #1;
        drive(32'h1234, 32'h0, 5'd5, 3'b000, 4'b0000, 1'b0, 1'b1);
        exp_q.push_back('{rd: 5'd5, reg_wr: 1'b1, data: 32'h1234, chk_data: 1'b1, mis: 1'b0});
        @(negedge clk);
        chk("alu_stall0", 32'(stall), 32'd0);
        chk("alu_req", 32'(dmem.req), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("alu_stall1", 32'(stall), 32'd0);

        // SB with gnt held off 3 cycles; garbage inputs while busy
        @(posedge clk); #1;
        drive(32'h103, 32'hAB, 5'd0, 3'b000, 4'b0001, 1'b0, 1'b0);
        exp_q.push_back('{rd: 5'd0, reg_wr: 1'b0, data: 32'h0, chk_data: 1'b0, mis: 1'b0});
        @(posedge clk); #1;
        in_addr = 32'hFFFF_FFFF;
        in_rv2  = 32'h5555_5555;
        in_dwe  = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("sb_stall", 32'(stall), 32'd1);
            chk("sb_req", 32'(dmem.req), 32'd1);
            chk("sb_we", 32'(dmem.we), 32'h8);
            chk("sb_addr", dmem.addr, 32'h100);
            chk("sb_wdata", dmem.wdata, 32'hAB00_0000);
            @(posedge clk); #1;
        end
        dmem.gnt = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("sb_req_gnt", 32'(dmem.req), 32'd1);
        @(posedge clk); #1;
        dmem.gnt = 1'b0;
        @(negedge clk);
        chk("sb_done_stall", 32'(stall), 32'd0);
        chk("sb_done_req", 32'(dmem.req), 32'd0);

        // loads
        do_load(32'h102, 3'b000, 32'h0080_FF00, 32'hFFFF_FF80);
        do_load(32'h102, 3'b100, 32'h0080_FF00, 32'h0000_0080);
        do_load(32'h102, 3'b001, 32'h8001_0000, 32'hFFFF_8001);
        do_load(32'h102, 3'b101, 32'h8001_0000, 32'h0000_8001);
        do_load(32'h100, 3'b010, 32'h8001_0000, 32'h8001_0000);
        do_load(32'h101, 3'b000, 32'h0000_7F00, 32'h0000_007F);

        // stores
        do_store(32'h102, 32'h1234_BEEF, 4'b0011, 4'b1100, 32'hBEEF_0000);
        do_store(32'h100, 32'hCAFE_F00D, 4'b1111, 4'b1111, 32'hCAFE_F00D);

`ifdef LSU_MISALIGN_CHECK_EN
        do_misalign(32'h102, 3'b010, 4'b0000, 1'b1);
        do_misalign(32'h101, 3'b001, 4'b0011, 1'b0);
        do_misalign(32'h103, 3'b010, 4'b1111, 1'b0);
`else
        do_store(32'h102, 32'h1122_3344, 4'b1111, 4'b1100, 32'h3344_0000);
        do_load(32'h103, 3'b001, 32'h8000_0000, 32'h0000_0080);
`endif

        // reset while waiting for read data; late rvalid ignored
        @(posedge clk); #1;
        drive(32'h100, 32'h0, 5'd9, 3'b010, 4'b0000, 1'b1, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        dmem.gnt = 1'b1;
        @(posedge clk); #1;
        dmem.gnt = 1'b0;
        chk("rw_stall_pre", 32'(stall), 32'd1);
        reset = 1'b1;
        #1;
        chk("rw_req", 32'(dmem.req), 32'd0);
        chk("rw_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        reset       = 1'b0;
        dmem.rvalid = 1'b1;
        dmem.rdata  = 32'h1234_5678;
        @(posedge clk); #1;
        dmem.rvalid = 1'b0;
        @(negedge clk);
        chk("rw_after_stall", 32'(stall), 32'd0);
        chk("rw_after_req", 32'(dmem.req), 32'd0);

        // reset while requesting drops req at once
        @(posedge clk); #1;
        drive(32'h200, 32'h77, 5'd4, 3'b010, 4'b1111, 1'b0, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rr_req_pre", 32'(dmem.req), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("rr_req", 32'(dmem.req), 32'd0);
        chk("rr_we", 32'(dmem.we), 32'd0);
        @(posedge clk); #1;
        reset    = 1'b0;
        dmem.gnt = 1'b1;
        @(posedge clk); #1;
        dmem.gnt = 1'b0;
        @(negedge clk);
        chk("rr_after_stall", 32'(stall), 32'd0);

        repeat (5) @(negedge clk);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
